inst_fetch_unit: RTL and testbench

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

---
 rtl/inst_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_inst_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Generic synchronous FIFO with flush; head entry is visible combinationally.
// Latency: a push is visible at the head one cycle later.
// Backpressure: a push into a full FIFO is accepted only with a same-cycle pop.
module sync_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign head_dat = mem[rd_ptr];

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // storage, pointers and occupancy; flush empties without touching storage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end
endmodule

// Instruction fetch front end: issues reads to the inst-side bridge, buffers 2 words.
// Latency: bridge response to if_valid is 1 cycle; one instruction per response.
// Backpressure: read requests stop while the 2-entry buffer is full (id_ready low).
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        sram_rd_en,
  output logic [31:0] sram_rd_addr,
  output logic        sram_cancel_rd,
  input  logic        sram_rd_valid,
  input  logic [31:0] sram_rd_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_ready
);
  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        outstanding;
  logic [1:0]  fifo_cnt;
  logic        push;
  logic        pop;
  logic        full_next;
  logic [63:0] head;

  // next fetch address: redirect beats response-advance beats hold
  always_comb begin
    sram_rd_addr = pc;
    if (redirect_valid)     sram_rd_addr = redirect_pc & 32'hffff_fffc;
    else if (sram_rd_valid) sram_rd_addr = pc + 32'd4;
  end

  // a response arriving with a redirect is already complete, so it is dropped, not cancelled
  assign sram_cancel_rd = redirect_valid & outstanding & ~sram_rd_valid;
  assign push           = sram_rd_valid & ~redirect_valid;
  assign pop            = if_valid & id_ready;
  assign if_valid       = (fifo_cnt != 2'd0);
  assign {if_pc, if_inst} = head;

  // predicts whether the buffer will be full after this edge
  always_comb begin
    full_next = 1'b0;
    if (!redirect_valid) begin
      if (fifo_cnt == 2'd2)      full_next = !pop || push;
      else if (fifo_cnt == 2'd1) full_next = push && !pop;
    end
  end

  // fetch control: boot for one cycle, then request while the buffer has room
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state      <= BOOT;
      sram_rd_en <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state      <= RUN;
          sram_rd_en <= 1'b1;
        end
        default: begin
          state      <= full_next ? HOLD : RUN;
          sram_rd_en <= !full_next;
        end
      endcase
    end
  end

  // pc tracks the oldest unanswered fetch address
  always_ff @(posedge ACLK) begin
    if (!ARESETn) pc <= RESET_PC;
    else          pc <= sram_rd_addr;
  end

  // a read is in flight while requesting; it ends on a response or a cancel
  always_ff @(posedge ACLK) begin
    if (!ARESETn)                             outstanding <= 1'b0;
    else if (sram_rd_en)                      outstanding <= 1'b1;
    else if (sram_rd_valid || sram_cancel_rd) outstanding <= 1'b0;
  end

  sync_fifo #(.W(64), .DEPTH(2)) u_fifo (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .flush    (redirect_valid),
    .push     (push),
    .push_dat ({pc, sram_rd_data}),
    .pop      (pop),
    .head_dat (head),
    .count    (fifo_cnt)
  );
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed literal scenarios plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_inst_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        sram_rd_en;
  logic [31:0] sram_rd_addr;
  logic        sram_cancel_rd;
  logic        sram_rd_valid = 1'b0;
  logic [31:0] sram_rd_data = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready = 1'b0;

  inst_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .ACLK           (ACLK),
    .ARESETn        (ARESETn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .sram_rd_en     (sram_rd_en),
    .sram_rd_addr   (sram_rd_addr),
    .sram_cancel_rd (sram_cancel_rd),
    .sram_rd_valid  (sram_rd_valid),
    .sram_rd_data   (sram_rd_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .id_ready       (id_ready)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: fetched-but-unconsumed instructions in order
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_out;
  bit          m_known = 0;
  int          m_age;

  // compare outputs mid-cycle, then advance the model to the next edge
  always @(negedge ACLK) begin
    logic [31:0] exp_addr;
    bit          exp_en;
    bit          exp_cancel;
    bit          do_pop;
    ent_t        e;
    if (m_known) begin
      exp_en = (m_age >= 1) && (q.size() < 2);
      if (redirect_valid)     exp_addr = {redirect_pc[31:2], 2'b00};
      else if (sram_rd_valid) exp_addr = m_pc + 32'd4;
      else                    exp_addr = m_pc;
      exp_cancel = redirect_valid && m_out && !sram_rd_valid;
      chk1("m_rd_en", sram_rd_en, exp_en);
      chk32("m_rd_addr", sram_rd_addr, exp_addr);
      chk1("m_cancel", sram_cancel_rd, exp_cancel);
      chk1("m_if_valid", if_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk32("m_if_pc", if_pc, q[0].pc);
        chk32("m_if_inst", if_inst, q[0].inst);
      end else if (m_age == 0) begin
        chk32("m_rst_if_pc", if_pc, 32'h0);
        chk32("m_rst_if_inst", if_inst, 32'h0);
      end
      if (ARESETn) begin
        do_pop = (q.size() != 0) && id_ready;
        if (redirect_valid) begin
          q.delete();
        end else begin
          if (do_pop) void'(q.pop_front());
          if (sram_rd_valid) begin
            e.pc   = m_pc;
            e.inst = sram_rd_data;
            q.push_back(e);
          end
        end
        if (exp_en)                             m_out = 1;
        else if (sram_rd_valid || exp_cancel)   m_out = 0;
        m_pc = exp_addr;
        m_age++;
      end
    end
    if (!ARESETn) begin
      q.delete();
      m_pc    = RST_PC;
      m_out   = 0;
      m_age   = 0;
      m_known = 1;
    end
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    repeat (3) step();
    ARESETn = 1'b1;
    #1;
    chk1("rst_rd_en", sram_rd_en, 1'b0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk1("rst_cancel", sram_cancel_rd, 1'b0);
    chk32("rst_if_pc", if_pc, 32'h0);
    chk32("rst_addr", sram_rd_addr, 32'h1c000000);

    // first fetches after boot
    step();
    chk1("run_rd_en", sram_rd_en, 1'b1);
    chk32("first_addr", sram_rd_addr, 32'h1c000000);
    sram_rd_valid = 1'b1; sram_rd_data = 32'h02800000;
    #1 chk32("second_addr", sram_rd_addr, 32'h1c000004);
    step();
    sram_rd_data = 32'h02800001;
    #1;
    chk1("first_if_valid", if_valid, 1'b1);
    chk32("first_if_pc", if_pc, 32'h1c000000);
    chk32("first_if_inst", if_inst, 32'h02800000);
    step();
    sram_rd_valid = 1'b0;
    #1;
    chk1("hold_rd_en", sram_rd_en, 1'b0);
    chk32("hold_head_pc", if_pc, 32'h1c000000);
    id_ready = 1'b1;
    step();
    chk1("resume_rd_en", sram_rd_en, 1'b1);
    chk32("pop2_pc", if_pc, 32'h1c000004);
    chk32("pop2_inst", if_inst, 32'h02800001);
    chk32("resume_addr", sram_rd_addr, 32'h1c000008);
    step();
    id_ready = 1'b0;
    #1 chk1("drained", if_valid, 1'b0);

    // redirect while a read is in flight
    sram_rd_valid = 1'b1; sram_rd_data = 32'haaaa0001;
    step();
    sram_rd_valid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h1c000103;
    #1;
    chk1("cancel_pulse", sram_cancel_rd, 1'b1);
    chk32("redir_addr", sram_rd_addr, 32'h1c000100);
    step();
    redirect_valid = 1'b0;
    #1;
    chk1("flushed", if_valid, 1'b0);
    chk1("cancel_single", sram_cancel_rd, 1'b0);
    chk32("redir_held", sram_rd_addr, 32'h1c000100);

    // redirect coincident with a response
    sram_rd_valid = 1'b1; sram_rd_data = 32'hdeadbeef;
    redirect_valid = 1'b1; redirect_pc = 32'h1c000200;
    #1;
    chk1("coinc_no_cancel", sram_cancel_rd, 1'b0);
    chk32("coinc_addr", sram_rd_addr, 32'h1c000200);
    step();
    sram_rd_valid = 1'b0; redirect_valid = 1'b0;
    #1;
    chk1("coinc_dropped", if_valid, 1'b0);
    chk32("coinc_pc", sram_rd_addr, 32'h1c000200);

    // pc wrap
    redirect_valid = 1'b1; redirect_pc = 32'hfffffffc;
    step();
    redirect_valid = 1'b0; sram_rd_valid = 1'b1; sram_rd_data = 32'h00000011;
    #1 chk32("wrap_addr", sram_rd_addr, 32'h00000000);
    step();
    sram_rd_valid = 1'b0;
    #1;
    chk32("wrap_if_pc", if_pc, 32'hfffffffc);
    chk32("wrap_if_inst", if_inst, 32'h00000011);
    chk32("wrap_pc", sram_rd_addr, 32'h00000000);

    // reset while full
    sram_rd_valid = 1'b1; sram_rd_data = 32'h00000022;
    step();
    sram_rd_valid = 1'b0;
    #1;
    chk1("full_rd_en", sram_rd_en, 1'b0);
    chk1("full_if_valid", if_valid, 1'b1);
    ARESETn = 1'b0;
    step();
    ARESETn = 1'b1;
    #1;
    chk1("mid_rst_if_valid", if_valid, 1'b0);
    chk1("mid_rst_rd_en", sram_rd_en, 1'b0);
    chk32("mid_rst_addr", sram_rd_addr, 32'h1c000000);
    step();
    chk1("restart_rd_en", sram_rd_en, 1'b1);
    chk32("restart_addr", sram_rd_addr, 32'h1c000000);

    // randomized traffic; the bridge only answers while a request is raised
    for (int c = 0; c < 3000; c++) begin
      step();
      ARESETn        = ($urandom_range(0, 499) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hfffffff0 + 32'($urandom_range(0, 15)))
                                                   : 32'($urandom);
      sram_rd_valid  = sram_rd_en && ARESETn && ($urandom_range(0, 2) != 0);
      sram_rd_data   = 32'($urandom);
      id_ready       = ((c / 40) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
    step();
    sram_rd_valid  = 1'b0;
    redirect_valid = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
